// File: rtl/uart_rx_os.sv
// UART receiver fed by a SMP_RATE-times oversampling baud strobe.
// Mid-bit sampling, LSB first, one-entry valid/ready holding register.
module uart_rx_os #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned SMP_RATE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned TICK_W = $clog2(SMP_RATE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(SMP_RATE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(SMP_RATE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e                 state_q, state_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic                   load_c;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        load_c  = 1'b0;

        if (baud_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_s) begin
                            state_d = S_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_END) begin
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q + BIT_W'(1) == BIT_LAST) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop-bit keeps a back-to-back start edge catchable.
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        if (rx_s) begin
                            load_c  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // A full holding register that is not being drained drops the new word.
        if (load_c) begin
            if (!valid_q || rx_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

UART receive stage that consumes the 16x oversampling `baud_tick` strobe from the baud-rate generator. It deserializes an asynchronous `rx` line (8N1 by default, LSB first) using mid-bit sampling. Each received word is delivered through a one-entry valid/ready holding register. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `DATA_BITS`, default 8: data bits per frame (5–9).
- `SMP_RATE`, default 16: `baud_tick` strobes per bit. Must be even and at least 4. Must match the generator's `smp_rate`.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high. Clock is `clk`.
- `baud_tick`, input, 1: one-`clk` strobe at `SMP_RATE` x baud.
- `rx`, input, 1: asynchronous serial line; idle is 1.
- `rx_data`, output, `DATA_BITS`: received word, valid while `rx_valid` is 1.
- `rx_valid`, output, 1: holding register is full.
- `rx_ready`, input, 1: consumer accepts the word. A transfer occurs on any `clk` edge where `rx_valid && rx_ready`.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled as 0.
- `overrun`, output, 1: one-cycle pulse when a completed word is dropped because the holding register is full.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Counters:** `tick_cnt` has width `$clog2(SMP_RATE)`; `bit_cnt` has width `$clog2(DATA_BITS+1)`. Both advance only on `clk` edges with `baud_tick` = 1. The FSM ignores `clk` edges without a tick, except for the output handshake.
- **IDLE:** on a tick with `rx_s` = 0, go to START with `tick_cnt` = 0.
- **START:**
  - On each tick, `tick_cnt` increments.
  - On the tick where `tick_cnt` == `SMP_RATE/2-1` (the mid-start-bit sample):
    - If `rx_s` = 0, go to DATA with `tick_cnt` = 0 and `bit_cnt` = 0.
    - If `rx_s` = 1, the start bit was a glitch. Return to IDLE with no flag.
- **DATA:**
  - On the tick where `tick_cnt` == `SMP_RATE-1`, shift right with `shreg` = {`rx_s`, `shreg[DATA_BITS-1:1]`}. Set `tick_cnt` = 0 and increment `bit_cnt`.
  - When `bit_cnt` reaches `DATA_BITS`, go to STOP.
  - On every other tick, increment `tick_cnt`.
- **STOP:** on the tick where `tick_cnt` == `SMP_RATE-1`, sample the stop bit.
  - If `rx_s` = 1, the word is good. Deliver it and go to IDLE. IDLE is entered at mid-stop-bit so that a back-to-back start edge is caught.
  - If `rx_s` = 0, pulse `frame_err`, discard the word, and go to BREAK.
- **BREAK:** stay until a tick with `rx_s` = 1, then go to IDLE. A held-low line therefore produces exactly one `frame_err`, not a repeated stream.
- **Delivery of a good word:**
  - If `rx_valid` is 0, or `rx_ready` is 1 in the same cycle: load `rx_data` and set `rx_valid` = 1. A simultaneous consume and load leaves `rx_valid` at 1 with the new data.
  - Otherwise: pulse `overrun`. `rx_data` keeps the old word and the new word is lost.
- **Handshake:** after a transfer with no simultaneous load, `rx_valid` = 0 on the next cycle. `rx_data` is held stable while `rx_valid` = 1.
- **Reset values:** state = IDLE, `tick_cnt` = `bit_cnt` = 0, `shreg` = 0, `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, synchronizer = 1.
- **Reset mid-frame:** the partial word is abandoned and no flags are pulsed.

## Timing
- `rx` falling edge to `rx_s` falling edge: 2 `clk`.
- Start is detected on the first tick after `rx_s` falls; this detection tick is called tick 0.
  - The mid-start check occurs on tick `SMP_RATE/2`, which is 8 for the defaults.
  - Data bit i is sampled on tick `SMP_RATE/2 + SMP_RATE*(i+1)`.
  - The stop bit is sampled on tick `SMP_RATE/2 + SMP_RATE*(DATA_BITS+1)`, which is 152 for the defaults.
- `rx_valid`, `frame_err` and `overrun` update on the same `clk` edge as the stop-bit sample tick. Their effect is visible the cycle after that edge.
- `frame_err` and `overrun` are high for exactly 1 `clk`.
- Tolerated receiver-to-transmitter baud mismatch is at least ±3%; this is a sampling-point property, not a checked function.

## Test plan
- **Single frame:** default parameters, tick every 4 `clk`, `rx_ready` = 0. Send 0xA5 as 8N1. Expect `rx_valid` rising after stop tick 152, `rx_data` = 0xA5, and `frame_err` = `overrun` = 0.
- **Start-bit glitch:** drive `rx` low for 3 ticks, then high. Expect the FSM back in IDLE by tick 8, with no `rx_valid`, no `frame_err`, and no `overrun`.
- **Framing error and break:** send 0x3C with the stop bit 0, then hold `rx` = 0 for 40 bit times, then release. Expect exactly one `frame_err` pulse and `rx_valid` staying 0. After release, 0x81 must be received correctly.
- **Overrun:** send 0x55 then 0xAA back to back with `rx_ready` = 0. Expect `rx_data` = 0x55 held, `rx_valid` = 1, and one `overrun` pulse at the 0xAA stop sample.
- **Streaming:** hold `rx_ready` = 1 and send 0x00, 0xFF, 0x5A back to back. Expect three one-cycle `rx_valid` pulses carrying 0x00, 0xFF, 0x5A, with no `overrun`. Then repeat with `rx_ready` asserted exactly on the load cycle to exercise the simultaneous consume-and-load.
- **Reset mid-frame:** assert `rst` for 1 `clk` during data bit 4. Expect all outputs at reset values and no pulses. A following 0xC3 frame must be received correctly.
